// File: rtl/debug_frame_rx_if.sv
// UART rx-buffer read handshake between the UART_Unit (master) and debug_frame_rx (slave).
interface debug_frame_rx_if;
  logic [7:0] r_data;
  logic       rx_ready;
  logic       rd_uart;

  modport master (output r_data, output rx_ready, input rd_uart);
  modport slave  (input r_data, input rx_ready, output rd_uart);
endinterface

// File: rtl/debug_frame_rx.sv
// Sync-framed byte-to-wide-word receiver for the debugger UART link.
// Define DEBUG_FRAME_RX_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module debug_frame_rx #(
  parameter int         NBYTES  = 220,
  parameter logic [7:0] SYNC    = 8'hA5,
  parameter int         TIMEOUT = 1000000
) (
  input  logic                 clock,
  input  logic                 reset,
  debug_frame_rx_if.slave      rx,
  output logic [NBYTES*8-1:0]  word_data,
  output logic                 word_valid,
  output logic                 frame_err,
  output logic                 busy
);
  localparam int              W        = NBYTES * 8;
  localparam int              TW       = $clog2(TIMEOUT + 1);
  localparam logic [7:0]      LAST     = 8'(NBYTES - 1);
  localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

`ifdef DEBUG_FRAME_RX_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_COLLECT = 2'd1, S_DONE = 2'd2, S_CHK = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_COLLECT = 2'd1, S_DONE = 2'd2} state_t;
`endif

  state_t        r_state;
  state_t        w_state_nx;
  logic          r_rd_uart;
  logic [7:0]    r_cnt;
  logic [TW-1:0] r_tmo;
  logic [W-1:0]  r_buf;
  logic          w_accept;
  logic          w_tmo_hit;
  logic          w_store;
  logic          w_word_load;
  logic          w_err;
`ifdef DEBUG_FRAME_RX_CHECKSUM_EN
  logic [7:0]    r_xor;
`endif

  // A pop in flight masks rx_ready so the same buffer head is never taken twice.
  assign w_accept  = rx.rx_ready && !r_rd_uart;
  // Fires on the cycle the counter would reach TIMEOUT; an accepted byte overrides it.
  assign w_tmo_hit = !w_accept && (r_tmo == TMO_LAST);
  assign rx.rd_uart = r_rd_uart;
  assign busy       = (r_state != S_IDLE);

  always_comb begin
    w_state_nx  = r_state;
    w_store     = 1'b0;
    w_word_load = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && (rx.r_data == SYNC)) w_state_nx = S_COLLECT;
      end
      S_COLLECT: begin
        if (w_accept) begin
          w_store = 1'b1;
          if (r_cnt == LAST) begin
`ifdef DEBUG_FRAME_RX_CHECKSUM_EN
            w_state_nx = S_CHK;
`else
            w_state_nx = S_DONE;
`endif
          end
        end else if (w_tmo_hit) begin
          w_err      = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
`ifdef DEBUG_FRAME_RX_CHECKSUM_EN
      S_CHK: begin
        if (w_accept) begin
          if (rx.r_data == r_xor) begin
            w_state_nx = S_DONE;
          end else begin
            w_err      = 1'b1;
            w_state_nx = S_IDLE;
          end
        end else if (w_tmo_hit) begin
          w_err      = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
`endif
      S_DONE: begin
        w_word_load = 1'b1;
        w_state_nx  = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_rd_uart  <= 1'b0;
      r_cnt      <= 8'd0;
      r_tmo      <= '0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      word_data  <= '0;
`ifdef DEBUG_FRAME_RX_CHECKSUM_EN
      r_xor      <= 8'd0;
`endif
    end else begin
      r_state    <= w_state_nx;
      r_rd_uart  <= w_accept;
      word_valid <= w_word_load;
      frame_err  <= w_err;
      if (w_word_load) word_data <= r_buf;

      if (r_state == S_IDLE) r_cnt <= 8'd0;
      else if (w_store)      r_cnt <= r_cnt + 8'd1;

      // Idle-gap counter only runs while waiting for in-frame bytes.
      if (w_accept || (r_state == S_IDLE) || (r_state == S_DONE)) r_tmo <= '0;
      else                                                        r_tmo <= r_tmo + 1'b1;

`ifdef DEBUG_FRAME_RX_CHECKSUM_EN
      if (r_state == S_IDLE) r_xor <= 8'd0;
      else if (w_store)      r_xor <= r_xor ^ rx.r_data;
`endif
    end
  end

  // Every slot is rewritten before DONE, so the assembly buffer needs no reset.
  always_ff @(posedge clock) begin
    if (w_store) r_buf[8*r_cnt +: 8] <= rx.r_data;
  end
endmodule
